// File: rtl/fm_write.sv
// fm_write: feature-map line-buffer writer.
// Takes a raster pixel stream and writes row r into row RAM (r mod 3) at
// address = column. Row-level credits (rows_filled / row_release) keep the
// writer from overwriting rows the downstream 3x3 window reader still needs.
// All RAM-side outputs are registered, one cycle after the accepted pixel.
// Optional feature macro: FM_WRITE_ZERO_PAD_EN
//   defined     -> each row is stored as W+2 entries with a zero at address 0
//                  and at address W+1; pixel column c lands at address c+1.
//   not defined -> no padding, pixel column c lands at address c.
module fm_write #(
    parameter int DW = 8,
    parameter int AW = 11
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            module_en,
    input  logic            refresh,
    input  logic [8:0]      fm_width,
    input  logic [8:0]      fm_height,
    input  logic            din_valid,
    input  logic [DW-1:0]   din,
    output logic            din_ready,
    input  logic            row_release,
    output logic [2:0]      ram_wen,
    output logic [3*AW-1:0] ram_waddr,
    output logic [DW-1:0]   ram_wdata,
    output logic [1:0]      rows_filled,
    output logic            frame_done
);

`ifdef FM_WRITE_ZERO_PAD_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_PAD_L = 3'd4,
        S_PAD_R = 3'd5
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [8:0]      colCnt_q, colCnt_d;
    logic [8:0]      rowCnt_q, rowCnt_d;
    logic [8:0]      width_q, width_d;
    logic [8:0]      height_q, height_d;
    logic [1:0]      wrSel_q, wrSel_d;
    logic [1:0]      rowsFilled_q, rowsFilled_d;
    logic [2:0]      wen_q, wen_d;
    logic [3*AW-1:0] waddr_q, waddr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic            frameDone_q, frameDone_d;

    logic            transfer;
    logic            lastCol;
    logic            lastRow;
    logic            rowDone;
    logic            wrValid;
    logic [AW-1:0]   wrAddr;
    logic [DW-1:0]   wrData;

    // Ready only depends on registered state so it never loops back through din_valid.
    always_comb begin
        din_ready = module_en && (state_q == S_WRITE) && (rowsFilled_q != 2'd3);
        transfer  = din_valid && din_ready;
        lastCol   = (colCnt_q == (width_q - 9'd1));
        lastRow   = (rowCnt_q == (height_q - 9'd1));
    end

    // Next-state, counters, credits and the registered RAM write port.
    always_comb begin
        state_d      = state_q;
        colCnt_d     = colCnt_q;
        rowCnt_d     = rowCnt_q;
        width_d      = width_q;
        height_d     = height_q;
        wrSel_d      = wrSel_q;
        rowsFilled_d = rowsFilled_q;
        wen_d        = 3'b000;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        frameDone_d  = 1'b0;
        rowDone      = 1'b0;
        wrValid      = 1'b0;
        wrAddr       = '0;
        wrData       = '0;

        case (state_q)
            S_IDLE: begin
                if (module_en && (fm_width != 9'd0) && (fm_height != 9'd0)) begin
                    width_d  = fm_width;
                    height_d = fm_height;
                    colCnt_d = 9'd0;
                    rowCnt_d = 9'd0;
`ifdef FM_WRITE_ZERO_PAD_EN
                    state_d  = S_PAD_L;
`else
                    state_d  = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                if (transfer) begin
                    wrValid = 1'b1;
`ifdef FM_WRITE_ZERO_PAD_EN
                    wrAddr  = AW'(colCnt_q) + AW'(1);
`else
                    wrAddr  = AW'(colCnt_q);
`endif
                    wrData  = din;
                    if (lastCol) begin
                        colCnt_d = 9'd0;
`ifdef FM_WRITE_ZERO_PAD_EN
                        state_d  = S_PAD_R;
`else
                        rowDone  = 1'b1;
`endif
                    end else begin
                        colCnt_d = colCnt_q + 9'd1;
                    end
                end
            end
`ifdef FM_WRITE_ZERO_PAD_EN
            S_PAD_L: begin
                if (module_en && (rowsFilled_q != 2'd3)) begin
                    wrValid = 1'b1;
                    wrAddr  = '0;
                    state_d = S_WRITE;
                end
            end
            S_PAD_R: begin
                if (module_en) begin
                    wrValid = 1'b1;
                    wrAddr  = AW'(width_q) + AW'(1);
                    rowDone = 1'b1;
                    state_d = S_PAD_L;
                end
            end
`endif
            S_WAIT: begin
                if (module_en && (rowsFilled_q != 2'd3)) begin
`ifdef FM_WRITE_ZERO_PAD_EN
                    state_d = S_PAD_L;
`else
                    state_d = S_WRITE;
`endif
                end
            end
            S_DONE: begin
                if (module_en) begin
                    frameDone_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wrValid) begin
            wen_d   = 3'b001 << wrSel_q;
            wdata_d = wrData;
            for (int k = 0; k < 3; k++) begin
                if (wrSel_q == 2'(k)) begin
                    waddr_d[k*AW +: AW] = wrAddr;
                end
            end
        end

        // A completed row and a release in the same cycle cancel out.
        if (rowDone && !row_release) begin
            rowsFilled_d = (rowsFilled_q == 2'd3) ? 2'd3 : rowsFilled_q + 2'd1;
        end else if (!rowDone && row_release && (rowsFilled_q != 2'd0)) begin
            rowsFilled_d = rowsFilled_q - 2'd1;
        end

        if (rowDone) begin
            rowCnt_d = rowCnt_q + 9'd1;
            wrSel_d  = (wrSel_q == 2'd2) ? 2'd0 : wrSel_q + 2'd1;
            if (lastRow) begin
                state_d = S_DONE;
            end else if (rowsFilled_d == 2'd3) begin
                state_d = S_WAIT;
            end
        end

        // Frame restart wins over everything and drops any write in flight.
        if (refresh) begin
            state_d      = S_IDLE;
            colCnt_d     = 9'd0;
            rowCnt_d     = 9'd0;
            wrSel_d      = 2'd0;
            rowsFilled_d = 2'd0;
            wen_d        = 3'b000;
            waddr_d      = waddr_q;
            wdata_d      = wdata_q;
            frameDone_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            colCnt_q     <= 9'd0;
            rowCnt_q     <= 9'd0;
            width_q      <= 9'd0;
            height_q     <= 9'd0;
            wrSel_q      <= 2'd0;
            rowsFilled_q <= 2'd0;
            wen_q        <= 3'b000;
            waddr_q      <= '0;
            wdata_q      <= '0;
            frameDone_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            colCnt_q     <= colCnt_d;
            rowCnt_q     <= rowCnt_d;
            width_q      <= width_d;
            height_q     <= height_d;
            wrSel_q      <= wrSel_d;
            rowsFilled_q <= rowsFilled_d;
            wen_q        <= wen_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            frameDone_q  <= frameDone_d;
        end
    end

    assign ram_wen     = wen_q;
    assign ram_waddr   = waddr_q;
    assign ram_wdata   = wdata_q;
    assign rows_filled = rowsFilled_q;
    assign frame_done  = frameDone_q;

endmodule
